// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv : shared RISC-V front-end types and instruction-length decode     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv;

  typedef logic [15:0] rv_parcel_t;

  typedef enum logic [2:0] {
    SIZE_16   = 3'd0,
    SIZE_32   = 3'd1,
    SIZE_48   = 3'd2,
    SIZE_64   = 3'd3,
    SIZE_VAR  = 3'd4,
    SIZE_RSVD = 3'd5
  } rv_inst_size_t;

  typedef enum logic [0:0] {
    RV_ALIGNER_RUN  = 1'b0,
    RV_ALIGNER_HALT = 1'b1
  } rv_aligner_state_t;

  localparam int unsigned RV_ALIGNER_DEPTH = 4;

  // Standard RISC-V length encoding taken from the first parcel only.
  function automatic rv_inst_size_t rv_get_inst_size(input rv_parcel_t hdr);
    rv_inst_size_t size;
    if (hdr[1:0] != 2'b11)           size = SIZE_16;
    else if (hdr[4:2] != 3'b111)     size = SIZE_32;
    else if (hdr[5] == 1'b0)         size = SIZE_48;
    else if (hdr[6] == 1'b0)         size = SIZE_64;
    else if (hdr[14:12] != 3'b111)   size = SIZE_VAR;
    else                             size = SIZE_RSVD;
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_parcel_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_parcel_buffer : 4-entry 16-bit parcel shift buffer                |
// | Pops 0/1/2 from the head and appends 0/1/2 in the same cycle.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_parcel_buffer
  import rv::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] push_cnt,
  input  rv_parcel_t push_p0,
  input  rv_parcel_t push_p1,
  input  logic [1:0] pop_cnt,
  output rv_parcel_t p0,
  output rv_parcel_t p1,
  output logic [2:0] count
);

  rv_parcel_t r_parcels [RV_ALIGNER_DEPTH];
  rv_parcel_t w_next    [RV_ALIGNER_DEPTH];
  logic [2:0] w_src     [RV_ALIGNER_DEPTH];
  logic [2:0] r_count;
  logic [2:0] w_rem;
  logic [2:0] w_next_count;

  // Survivors shift down by pop_cnt; new parcels land right after them.
  always_comb begin
    w_rem        = r_count - {1'b0, pop_cnt};
    w_next_count = w_rem + {1'b0, push_cnt};
    for (int i = 0; i < RV_ALIGNER_DEPTH; i++) begin
      w_src[i]  = 3'(i) + {1'b0, pop_cnt};
      w_next[i] = r_parcels[i];
      if (3'(i) < w_rem)
        w_next[i] = r_parcels[w_src[i][1:0]];
      else if ((3'(i) == w_rem) && (push_cnt != 2'd0))
        w_next[i] = push_p0;
      else if ((3'(i) == (w_rem + 3'd1)) && (push_cnt == 2'd2))
        w_next[i] = push_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= 3'd0;
      for (int i = 0; i < RV_ALIGNER_DEPTH; i++) r_parcels[i] <= '0;
    end else begin
      r_count <= w_next_count;
      for (int i = 0; i < RV_ALIGNER_DEPTH; i++) r_parcels[i] <= w_next[i];
    end
  end

  assign p0    = r_parcels[0];
  assign p1    = r_parcels[1];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rv_inst_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_inst_aligner : fetch-word to instruction aligner                  |
// | Splits fetch words into parcels and emits one 16/32-bit instruction. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_inst_aligner
  import rv::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_offset,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_compressed,
  output logic        inst_illegal
);

  rv_aligner_state_t r_state;
  rv_aligner_state_t w_state_next;
  rv_parcel_t        w_p0;
  rv_parcel_t        w_p1;
  logic [2:0]        w_count;
  rv_inst_size_t     w_size;
  logic              w_is16;
  logic              w_is32;
  logic              w_bad_len;
  logic              w_fire_in;
  logic              w_fire_out;
  logic [1:0]        w_pop_cnt;
  logic [1:0]        w_push_cnt;
  rv_parcel_t        w_push_p0;
  rv_parcel_t        w_push_p1;
  logic [2:0]        w_rem;
  logic [31:0]       r_head_pc;

  rv_parcel_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push_cnt (w_push_cnt),
    .push_p0  (w_push_p0),
    .push_p1  (w_push_p1),
    .pop_cnt  (w_pop_cnt),
    .p0       (w_p0),
    .p1       (w_p1),
    .count    (w_count)
  );

  assign w_size    = rv_get_inst_size(w_p0);
  assign w_is16    = (w_size == SIZE_16);
  assign w_is32    = (w_size == SIZE_32);
  assign w_bad_len = !w_is16 && !w_is32;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RV_ALIGNER_RUN;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush)
      w_state_next = RV_ALIGNER_RUN;
    else if (w_fire_out && w_bad_len)
      w_state_next = RV_ALIGNER_HALT;
  end

  // Output logic; everything on the decode side comes from registers.
  always_comb begin
    fetch_ready     = !rst && !flush && (r_state == RV_ALIGNER_RUN) && (w_count <= 3'd2);
    inst_valid      = (r_state == RV_ALIGNER_RUN) &&
                      (w_is32 ? (w_count >= 3'd2) : (w_count >= 3'd1));
    inst_data       = w_is32 ? {w_p1, w_p0} : {16'h0, w_p0};
    inst_pc         = r_head_pc;
    inst_compressed = inst_valid && w_is16;
    inst_illegal    = inst_valid && w_bad_len;
  end

  assign w_fire_in  = fetch_valid && fetch_ready;
  assign w_fire_out = inst_valid && inst_ready && !flush && !rst;

  // Illegal headers are never popped so they stay visible while halted.
  always_comb begin
    w_pop_cnt = 2'd0;
    if (w_fire_out && w_is16) w_pop_cnt = 2'd1;
    if (w_fire_out && w_is32) w_pop_cnt = 2'd2;
  end

  always_comb begin
    w_push_cnt = 2'd0;
    if (w_fire_in) w_push_cnt = fetch_offset ? 2'd1 : 2'd2;
    w_push_p0  = fetch_offset ? fetch_data[31:16] : fetch_data[15:0];
    w_push_p1  = fetch_data[31:16];
  end

  assign w_rem = w_count - {1'b0, w_pop_cnt};

  // An empty buffer re-seeds the PC from the fetch address.
  always_ff @(posedge clk) begin
    if (rst)
      r_head_pc <= RESET_PC;
    else if (flush)
      r_head_pc <= r_head_pc;
    else if (w_fire_in && (w_rem == 3'd0))
      r_head_pc <= fetch_pc + (fetch_offset ? 32'd2 : 32'd0);
    else
      r_head_pc <= r_head_pc + {29'd0, w_pop_cnt, 1'b0};
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_inst_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_inst_aligner : directed + random bench with parcel-queue model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_inst_aligner;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_data = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_offset = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_compressed;
  logic        inst_illegal;

  rv_inst_aligner #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_data      (fetch_data),
    .fetch_pc        (fetch_pc),
    .fetch_offset    (fetch_offset),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_compressed (inst_compressed),
    .inst_illegal    (inst_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of parcels, the PC of its head, halt flag.
  logic [15:0] q[$];
  logic [31:0] mpc;
  bit          mhalt = 0;
  bit          known = 0;
  bit          acc;

  function automatic int hdr_len(input logic [15:0] h);
    if (h[1:0] != 2'b11) return 16;
    if (h[4:2] != 3'b111) return 32;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fv, input logic [31:0] d, input logic [31:0] pc,
                       input bit off, input bit ir, input bit fl);
    fetch_valid = fv; fetch_data = d; fetch_pc = pc;
    fetch_offset = off; inst_ready = ir; flush = fl;
  endtask

  task automatic cycle();
    bit ev, er;
    int len, need;
    ev = 0; er = 0; len = 0; acc = 0;
    @(negedge clk);
    if (known) begin
      er = !rst && !flush && !mhalt && (q.size() <= 2);
      if (!mhalt && q.size() > 0) begin
        len  = hdr_len(q[0]);
        need = (len == 32) ? 2 : 1;
        ev   = (q.size() >= need);
      end
      chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, er});
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, ev});
      chk("inst_pc", inst_pc, mpc);
      chk("count", {29'd0, dut.u_buf.count}, q.size());
      if (ev) begin
        chk("inst_data", inst_data, (len == 32) ? {q[1], q[0]} : {16'h0, q[0]});
        chk("inst_compressed", {31'd0, inst_compressed}, {31'd0, len == 16});
        chk("inst_illegal", {31'd0, inst_illegal}, {31'd0, len == 0});
      end
    end
    if (rst) begin
      q.delete(); mpc = RST_PC; mhalt = 0; known = 1;
    end else if (known) begin
      if (flush) begin
        q.delete(); mhalt = 0;
      end else begin
        if (ev && inst_ready) begin
          if (len == 0) mhalt = 1;
          else if (len == 16) begin void'(q.pop_front()); mpc += 2; end
          else begin void'(q.pop_front()); void'(q.pop_front()); mpc += 4; end
        end
        if (er && fetch_valid) begin
          if (q.size() == 0) mpc = fetch_pc + (fetch_offset ? 32'd2 : 32'd0);
          if (!fetch_offset) q.push_back(fetch_data[15:0]);
          q.push_back(fetch_data[31:16]);
          acc = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cycle();
    end
  endtask

  task automatic do_flush();
    drive(0, 32'h0, 32'h0, 0, 1, 1);
    cycle();
  endtask

  logic [31:0] bp_words [3];
  logic [31:0] nxt_pc;
  logic [31:0] rdata;
  bit          first, fl, rs;
  int          idx;

  initial begin
    // Reset
    rst = 1; drive(0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    rst = 0;
    idle(1);

    // Aligned stream
    drive(1, 32'h0000_0013, 32'h100, 0, 1, 0); cycle();
    drive(1, 32'h0010_0093, 32'h104, 0, 1, 0); cycle();
    idle(3);

    // Compressed pair
    do_flush();
    drive(1, 32'h4001_4501, 32'h200, 0, 1, 0); cycle();
    idle(3);

    // Straddle
    do_flush();
    drive(1, 32'h0013_4501, 32'h300, 0, 1, 0); cycle();
    drive(1, 32'hABCD_0000, 32'h304, 0, 1, 0); cycle();
    idle(4);

    // Backpressure
    do_flush();
    bp_words[0] = 32'h0000_0013; bp_words[1] = 32'h4001_4501; bp_words[2] = 32'h0093_4505;
    idx = 0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      drive(1, bp_words[idx], 32'h500 + 32'(idx * 4), 0, c >= 6, 0);
      cycle();
      if (acc) idx++;
    end
    chk("bp_accept_all", idx, 3);
    idle(6);

    // Illegal length, halt, then recover
    do_flush();
    drive(1, 32'h0013_003F, 32'h600, 0, 1, 0); cycle();
    for (int c = 0; c < 4; c++) begin
      drive(1, 32'h0000_0013, 32'h604, 0, 1, 0); cycle();
    end
    do_flush();
    drive(1, 32'h0000_0013, 32'h700, 0, 1, 0); cycle();
    idle(2);

    // Offset redirect while a 32-bit instruction is half-buffered
    do_flush();
    drive(1, 32'h0013_4501, 32'h300, 0, 1, 0); cycle();
    idle(1);
    drive(1, 32'h1111_2222, 32'h304, 0, 1, 1); cycle();
    drive(1, 32'h0093_0000, 32'h400, 1, 1, 0); cycle();
    drive(1, 32'h0000_0000, 32'h404, 0, 1, 0); cycle();
    idle(3);

    // Reset while halted
    do_flush();
    drive(1, 32'h0000_003F, 32'h800, 0, 1, 0); cycle();
    idle(3);
    rst = 1; idle(1); rst = 0;
    drive(1, 32'h4001_4501, 32'h900, 0, 1, 0); cycle();
    idle(3);

    // Randomized traffic
    do_flush();
    first  = 1;
    nxt_pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      rs    = ($urandom_range(0, 499) == 0);
      fl    = ($urandom_range(0, 63) == 0) || (mhalt && ($urandom_range(0, 3) == 0));
      rdata = $urandom;
      rst   = rs;
      drive($urandom_range(0, 3) != 0, rdata, nxt_pc,
            first && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0, fl);
      cycle();
      if (rs || fl) begin
        nxt_pc = $urandom & 32'hFFFF_FFFC;
        first  = 1;
      end else if (acc) begin
        nxt_pc += 4;
        first  = 0;
      end
    end
    rst = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
